product_accumulator: RTL and testbench

//  Downstream consumer of the 4x4 array multiplier. Accepts a stream of 8-bit

---
 rtl/product_accumulator_if.sv | 40 ++++
 rtl/product_accumulator.sv | 120 ++++++++++++
 tb/tb_product_accumulator.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/product_accumulator_if.sv
// ---------------------------------------------------------------------------
// product_accumulator_if
// Bundles the two valid/ready handshakes and the control/status signals of
// product_accumulator.
//   slave  modport : the accumulator side (consumes products, produces sums)
//   master modport : the producer/consumer side that drives the accumulator
// Signals
//   start, num_terms        : run control (master -> slave)
//   in_valid, in_prod       : product stream (master -> slave)
//   in_ready                : product stream back-pressure (slave -> master)
//   out_valid, out_sum,
//   out_ovf                 : result stream (slave -> master)
//   out_ready               : result back-pressure (master -> slave)
//   busy                    : accumulator is not idle (slave -> master)
// ---------------------------------------------------------------------------
interface product_accumulator_if #(
  parameter int ACC_W = 12,
  parameter int CNT_W = 4
);
  logic             start;
  logic [CNT_W-1:0] num_terms;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_prod;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_ovf;
  logic             busy;

  modport slave (
    input  start, num_terms, in_valid, in_prod, out_ready,
    output in_ready, out_valid, out_sum, out_ovf, busy
  );

  modport master (
    output start, num_terms, in_valid, in_prod, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf, busy
  );
endinterface

// File: rtl/product_accumulator.sv
// ---------------------------------------------------------------------------
// product_accumulator
// Sums a programmed number of 8-bit products (a dot product) taken from a
// valid/ready stream and returns the total over a second valid/ready
// handshake.
// Ports
//   clk     : rising-edge clock
//   rst     : asynchronous reset, active-high
//   acc_if  : product_accumulator_if.slave (start/num_terms, product stream,
//             result stream, busy)
// Parameters
//   ACC_W   : accumulator / result width (>= 8)
//   CNT_W   : term-count width; up to 2**CNT_W-1 terms per run
// Configuration macro
//   SATURATE_EN : when defined, the accumulator clamps at 2**ACC_W-1 on carry
//                 out; otherwise it wraps. out_ovf sets in both cases.
// ---------------------------------------------------------------------------
module product_accumulator #(
  parameter int ACC_W = 12,
  parameter int CNT_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  product_accumulator_if.slave  acc_if
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q,   acc_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [CNT_W-1:0] terms_q, terms_d;
  logic             ovf_q,   ovf_d;

  // One extra bit captures the carry out of the ACC_W-bit add.
  logic [ACC_W:0]   sum_ext;
  assign sum_ext = {1'b0, acc_q} + (ACC_W+1)'(acc_if.in_prod);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    terms_d = terms_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (acc_if.start) begin
          terms_d = acc_if.num_terms;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          // A zero-term run has nothing to collect and reports 0 directly.
          state_d = (acc_if.num_terms == '0) ? DONE : ACCUM;
        end
      end

      ACCUM: begin
        // in_ready is high throughout ACCUM, so in_valid alone marks a transfer.
        if (acc_if.in_valid) begin
          cnt_d = cnt_q + 1'b1;
          if (sum_ext[ACC_W]) begin
            ovf_d = 1'b1;
`ifdef SATURATE_EN
            // Once clamped, any later non-zero product carries again, so the
            // value stays at full scale for the rest of the run.
            acc_d = '1;
`else
            acc_d = sum_ext[ACC_W-1:0];
`endif
          end else begin
            acc_d = sum_ext[ACC_W-1:0];
          end
          if (cnt_d == terms_q) state_d = DONE;
        end
      end

      DONE: begin
        // A start arriving together with out_ready is dropped on purpose.
        if (acc_if.out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value regardless of statement order.
  // NOTE: every register, including the datapath, is reset so an aborted run
  // cannot leak a partial sum or overflow flag into the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      terms_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      terms_q <= terms_d;
      ovf_q   <= ovf_d;
    end
  end

  // All outputs come straight from registers or a state decode.
  assign acc_if.in_ready  = (state_q == ACCUM);
  assign acc_if.out_valid = (state_q == DONE);
  assign acc_if.busy      = (state_q != IDLE);
  assign acc_if.out_sum   = acc_q;
  assign acc_if.out_ovf   = ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// ---------------------------------------------------------------------------
// tb_product_accumulator
// Directed bench for product_accumulator: a table of runs with hand-computed
// sums, plus hand-written sequences for zero terms, result back-pressure with
// ignored starts, overflow on a narrow accumulator, and mid-run reset.
// ---------------------------------------------------------------------------
module tb_product_accumulator;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  product_accumulator_if #(.ACC_W(12), .CNT_W(4)) pa ();
  product_accumulator_if #(.ACC_W(10), .CNT_W(4)) pa10 ();

  product_accumulator #(.ACC_W(12), .CNT_W(4)) u_dut (
    .clk    (clk),
    .rst    (rst),
    .acc_if (pa)
  );

  product_accumulator #(.ACC_W(10), .CNT_W(4)) u_dut10 (
    .clk    (clk),
    .rst    (rst),
    .acc_if (pa10)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [3:0]      n;
    logic [3:0][7:0] p;
    logic [3:0]      gap;
    logic [11:0]     exp_sum;
    logic            exp_ovf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [3:0] n);
    pa.start     = 1'b1;
    pa.num_terms = n;
    tick();
    pa.start     = 1'b0;
  endtask

  // Present one product after 'gaps' idle cycles; in_valid is left high so
  // back-to-back calls with gaps=0 form a continuous burst.
  task automatic feed(input logic [7:0] p, input int gaps);
    if (gaps > 0) begin
      pa.in_valid = 1'b0;
      repeat (gaps) begin
        tick();
        check("gap_no_out_valid", pa.out_valid, 1'b0);
      end
    end
    pa.in_valid = 1'b1;
    pa.in_prod  = p;
    for (int k = 0; k < 20 && !pa.in_ready; k++) tick();
    check("in_ready_wait", pa.in_ready, 1'b1);
    tick();
  endtask

  // Result must be present now (cycle after the last transfer); then drain it.
  task automatic collect(input string name, input logic [11:0] exp_sum, input logic exp_ovf);
    pa.in_valid = 1'b0;
    check({name, "_out_valid"}, pa.out_valid, 1'b1);
    check({name, "_out_sum"},   pa.out_sum,   exp_sum);
    check({name, "_out_ovf"},   pa.out_ovf,   exp_ovf);
    check({name, "_in_ready"},  pa.in_ready,  1'b0);
    pa.out_ready = 1'b1;
    tick();
    pa.out_ready = 1'b0;
    check({name, "_drop_valid"}, pa.out_valid, 1'b0);
    check({name, "_idle"},       pa.busy,      1'b0);
  endtask

  vec_t vecs [5];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    //           n     products (p[3..0])            gap   sum      ovf
    vecs[0] = '{4'd3, {8'd0, 8'd1, 8'd100, 8'd225}, 4'd0, 12'd326, 1'b0};
    vecs[1] = '{4'd2, {8'd0, 8'd0, 8'd16,  8'd9},   4'd3, 12'd25,  1'b0};
    vecs[2] = '{4'd4, {8'd10, 8'd10, 8'd10, 8'd10}, 4'd0, 12'd40,  1'b0};
    vecs[3] = '{4'd4, {8'd225, 8'd225, 8'd225, 8'd225}, 4'd1, 12'd900, 1'b0};
    vecs[4] = '{4'd1, {8'd0, 8'd0, 8'd0, 8'd0},     4'd0, 12'd0,   1'b0};

    pa.start = 1'b0; pa.num_terms = '0; pa.in_valid = 1'b0;
    pa.in_prod = '0; pa.out_ready = 1'b0;
    pa10.start = 1'b0; pa10.num_terms = '0; pa10.in_valid = 1'b0;
    pa10.in_prod = '0; pa10.out_ready = 1'b0;

    // Reset state.
    repeat (2) tick();
    check("rst_out_valid", pa.out_valid, 1'b0);
    check("rst_in_ready",  pa.in_ready,  1'b0);
    check("rst_busy",      pa.busy,      1'b0);
    check("rst_out_sum",   pa.out_sum,   12'd0);
    check("rst_out_ovf",   pa.out_ovf,   1'b0);
    rst = 1'b0;
    tick();

    // Table-driven runs.
    for (int i = 0; i < 5; i++) begin
      do_start(vecs[i].n);
      check($sformatf("v%0d_busy", i), pa.busy, 1'b1);
      for (int j = 0; j < int'(vecs[i].n); j++) feed(vecs[i].p[j], int'(vecs[i].gap));
      collect($sformatf("v%0d", i), vecs[i].exp_sum, vecs[i].exp_ovf);
    end

    // Maximum term count: 15 * 225 = 3375, no overflow.
    do_start(4'd15);
    for (int j = 0; j < 15; j++) feed(8'd225, 0);
    collect("max_terms", 12'd3375, 1'b0);

    // Zero terms: DONE immediately, no in_ready pulse.
    do_start(4'd0);
    check("zero_in_ready", pa.in_ready, 1'b0);
    collect("zero", 12'd0, 1'b0);

    // Result back-pressure with start pulses: held, no restart.
    do_start(4'd3);
    feed(8'd225, 0); feed(8'd100, 0); feed(8'd1, 0);
    pa.in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      pa.start     = (k % 2 == 0);
      pa.num_terms = 4'd2;
      tick();
      check("hold_out_valid", pa.out_valid, 1'b1);
      check("hold_out_sum",   pa.out_sum,   12'd326);
      check("hold_busy",      pa.busy,      1'b1);
    end
    pa.start = 1'b1; pa.out_ready = 1'b1;
    tick();
    pa.start = 1'b0; pa.out_ready = 1'b0;
    check("hold_release_valid", pa.out_valid, 1'b0);
    check("hold_release_busy",  pa.busy,      1'b0);
    tick();
    check("hold_start_dropped", pa.busy, 1'b0);

    // Narrow accumulator: 5 * 225 = 1125 exceeds 1023.
    pa10.start = 1'b1; pa10.num_terms = 4'd5;
    tick();
    pa10.start = 1'b0;
    pa10.in_valid = 1'b1; pa10.in_prod = 8'd225;
    for (int k = 0; k < 5; k++) begin
      check("ovf_in_ready", pa10.in_ready, 1'b1);
      tick();
    end
    pa10.in_valid = 1'b0;
    check("ovf_out_valid", pa10.out_valid, 1'b1);
`ifdef SATURATE_EN
    check("ovf_out_sum", pa10.out_sum, 10'd1023);
`else
    check("ovf_out_sum", pa10.out_sum, 10'd101);
`endif
    check("ovf_out_ovf", pa10.out_ovf, 1'b1);
    pa10.out_ready = 1'b1;
    tick();
    pa10.out_ready = 1'b0;
    check("ovf_idle", pa10.busy, 1'b0);
    check("ovf_sticky_until_start", pa10.out_ovf, 1'b1);

    // Mid-run reset after 2 of 4 transfers, then a clean run.
    do_start(4'd4);
    feed(8'd10, 0); feed(8'd10, 0);
    pa.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("abort_busy",      pa.busy,      1'b0);
    check("abort_in_ready",  pa.in_ready,  1'b0);
    check("abort_out_valid", pa.out_valid, 1'b0);
    check("abort_out_sum",   pa.out_sum,   12'd0);
    tick();
    rst = 1'b0;
    tick();
    do_start(4'd4);
    for (int j = 0; j < 4; j++) feed(8'd10, 0);
    collect("after_abort", 12'd40, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
